// File: rtl/lc3_mem_pkg.sv
// ---------------------------------------------------------------------------
// lc3_mem_pkg
//   Shared definitions for the LC-3 memory controller:
//     - access FSM state encoding (IDLE / WAIT / DONE)
//     - device register byte offsets from the device base address
//     - status register bit positions (ready, interrupt enable)
//     - small helpers for device decode and status word assembly
// ---------------------------------------------------------------------------
package lc3_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Device register offsets from DEV_BASE
   localparam int KBSR_OFF = 0;
   localparam int KBDR_OFF = 2;
   localparam int DSR_OFF  = 4;
   localparam int DDR_OFF  = 6;

   // Status register bit positions
   localparam int READY_BIT = 15;
   localparam int IE_BIT    = 14;

   // Device index used by the address decoder
   localparam int N_DEV    = 4;
   localparam int DEV_KBSR = 0;
   localparam int DEV_KBDR = 1;
   localparam int DEV_DSR  = 2;
   localparam int DEV_DDR  = 3;

   // Map a device index onto its byte offset from DEV_BASE
   function automatic int dev_off(input int idx);
      int off;
      off = KBSR_OFF;
      case (idx)
         DEV_KBSR: off = KBSR_OFF;
         DEV_KBDR: off = KBDR_OFF;
         DEV_DSR:  off = DSR_OFF;
         DEV_DDR:  off = DDR_OFF;
         default:  off = KBSR_OFF;
      endcase
      return off;
   endfunction

   // Assemble a 16-bit status word from its two live bits
   function automatic logic [15:0] status_word(input logic ready, input logic ie);
      logic [15:0] w;
      w            = '0;
      w[READY_BIT] = ready;
      w[IE_BIT]    = ie;
      return w;
   endfunction

endpackage

// File: rtl/lc3_sram.sv
// ---------------------------------------------------------------------------
// lc3_sram
//   Single-port synchronous word memory. Address is taken combinationally,
//   the read data is registered (one clock of read latency), and a write
//   returns the old contents on the same edge. Contents are never reset.
//
//   Ports:
//     clk    clock
//     we     write enable (writes wdata to addr on the rising edge)
//     addr   word address, MEM_AW bits
//     wdata  write data, DATA_W bits
//     rdata  registered read data for the address of the previous cycle
// ---------------------------------------------------------------------------
module lc3_sram #(
   parameter int DATA_W = 16,
   parameter int MEM_AW = 12
) (
   input  logic              clk,
   input  logic              we,
   input  logic [MEM_AW-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_mem_ctrl
//   LC-3 memory controller: owns MAR/MDR, a wait-stated SRAM, and the
//   memory-mapped keyboard/display registers (KBSR/KBDR/DSR/DDR).
//   An access is requested with mio_en (held until r); r pulses for one
//   cycle when the access completes. SRAM accesses take MEM_LAT+1 cycles,
//   device register accesses take one cycle.
//
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     bus_in                main bus value (source for MAR and MDR loads)
//     ld_mar                load MAR from bus_in
//     ld_mdr                load MDR (read data when mio_en, else bus_in)
//     mio_en                access request, held until r
//     rw                    1 = write, 0 = read, sampled at access start
//     mdr_out               MDR contents
//     r                     access complete, one-cycle pulse
//     kbd_data/valid/ready  keyboard byte handshake
//     disp_data/valid/ready display byte handshake
//     intr_req              registered level interrupt request
// ---------------------------------------------------------------------------
module lc3_mem_ctrl
   import lc3_mem_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter int                MEM_AW   = 12,
   parameter int                MEM_LAT  = 2,
   parameter logic [ADDR_W-1:0] DEV_BASE = 16'hFE00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              ld_mar,
   input  logic              ld_mdr,
   input  logic              mio_en,
   input  logic              rw,
   output logic [DATA_W-1:0] mdr_out,
   output logic              r,
   input  logic [7:0]        kbd_data,
   input  logic              kbd_valid,
   output logic              kbd_ready,
   output logic [7:0]        disp_data,
   output logic              disp_valid,
   input  logic              disp_ready,
   output logic              intr_req
);

   // Wait counter holds MEM_LAT-1 down to 0; keep at least one bit
   localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   // Architectural registers
   logic [ADDR_W-1:0] mar_reg;
   logic [DATA_W-1:0] mdr_reg;

   // Access FSM
   state_t            state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [ADDR_W-1:0] addr_q;
   logic              rw_q;
   logic              r_reg;

   // Device registers; only the live bits of the status words are stored
   logic              kbsr_ready_reg;   // KBSR[15]: a byte is waiting in KBDR
   logic              kbsr_ie_reg;      // KBSR[14]
   logic [7:0]        kbdr_reg;
   logic              dsr_ready_reg;    // DSR[15]: display can take a byte
   logic              dsr_ie_reg;       // DSR[14]
   logic [DATA_W-1:0] ddr_reg;
   logic              disp_valid_reg;
   logic              intr_reg;

   // Decode / datapath
   logic [N_DEV-1:0]  sel_q;            // addr_q hits device register gi
   logic [N_DEV-1:0]  sel_mar;          // MAR hits device register gi
   logic              addr_below_top;
   logic              addr_in_sram;
   logic              rd_done;
   logic              wr_done;
   logic              sram_we;
   logic [DATA_W-1:0] sram_rdata;
   logic [DATA_W-1:0] rd_data;

   // -----------------------------------------------------------------------
   // Address decode
   // -----------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < N_DEV; gi++) begin : g_dev_dec
         localparam logic [ADDR_W-1:0] DEV_ADDR = DEV_BASE + ADDR_W'(dev_off(gi));
         assign sel_q[gi]   = (addr_q  == DEV_ADDR);
         assign sel_mar[gi] = (mar_reg == DEV_ADDR);
      end
   endgenerate

   generate
      if (MEM_AW < ADDR_W) begin : g_range
         assign addr_below_top = (addr_q[ADDR_W-1:MEM_AW] == '0);
      end else begin : g_full
         assign addr_below_top = 1'b1;
      end
   endgenerate

   // Everything at or above DEV_BASE that is not a device register behaves
   // like an unpopulated SRAM location, even if it would fit the array.
   assign addr_in_sram = addr_below_top && (addr_q < DEV_BASE);

   assign rd_done = (state_reg == DONE) && !rw_q;
   assign wr_done = (state_reg == DONE) &&  rw_q;
   assign sram_we = wr_done && addr_in_sram;

   // -----------------------------------------------------------------------
   // SRAM: addressed from addr_q for the whole access, so the registered
   // read output already holds mem[addr_q] by the time DONE is reached.
   // -----------------------------------------------------------------------
   lc3_sram #(
      .DATA_W (DATA_W),
      .MEM_AW (MEM_AW)
   ) u_sram (
      .clk   (clk),
      .we    (sram_we),
      .addr  (addr_q[MEM_AW-1:0]),
      .wdata (mdr_reg),
      .rdata (sram_rdata)
   );

   // Read data seen in DONE: device register, SRAM word, or zero
   always_comb begin
      rd_data = '0;
      if (sel_q[DEV_KBSR]) begin
         rd_data = DATA_W'(status_word(kbsr_ready_reg, kbsr_ie_reg));
      end else if (sel_q[DEV_KBDR]) begin
         rd_data = DATA_W'(kbdr_reg);
      end else if (sel_q[DEV_DSR]) begin
         rd_data = DATA_W'(status_word(dsr_ready_reg, dsr_ie_reg));
      end else if (sel_q[DEV_DDR]) begin
         rd_data = ddr_reg;
      end else if (addr_in_sram) begin
         rd_data = sram_rdata;
      end
   end

   // -----------------------------------------------------------------------
   // Access FSM with registered r
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         addr_q    <= '0;
         rw_q      <= 1'b0;
         r_reg     <= 1'b0;
      end else begin
         r_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (mio_en) begin
                  addr_q  <= mar_reg;
                  rw_q    <= rw;
                  cnt_reg <= CNT_LOAD;
                  if (|sel_mar) begin
                     // Device registers need no wait states
                     state_reg <= DONE;
                     r_reg     <= 1'b1;
                  end else begin
                     state_reg <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!mio_en) begin
                  // Requester withdrew: abandon without write or r
                  state_reg <= IDLE;
               end else if (cnt_reg == '0) begin
                  state_reg <= DONE;
                  r_reg     <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // MAR / MDR
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mar_reg <= '0;
         mdr_reg <= '0;
      end else begin
         if (ld_mar) begin
            mar_reg <= ADDR_W'(bus_in);
         end
         if (ld_mdr) begin
            if (!mio_en) begin
               mdr_reg <= bus_in;
            end else if (rd_done) begin
               mdr_reg <= rd_data;
            end
         end
      end
   end

   // -----------------------------------------------------------------------
   // Keyboard / display registers and interrupt
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kbsr_ready_reg <= 1'b0;
         kbsr_ie_reg    <= 1'b0;
         kbdr_reg       <= '0;
         dsr_ready_reg  <= 1'b1;
         dsr_ie_reg     <= 1'b0;
         ddr_reg        <= '0;
         disp_valid_reg <= 1'b0;
         intr_reg       <= 1'b0;
      end else begin
         // Reading KBDR consumes the byte; a new accept below overrides
         if (rd_done && sel_q[DEV_KBDR]) begin
            kbsr_ready_reg <= 1'b0;
         end
         if (kbd_valid && !kbsr_ready_reg) begin
            kbdr_reg       <= kbd_data;
            kbsr_ready_reg <= 1'b1;
         end

         if (wr_done && sel_q[DEV_KBSR]) begin
            kbsr_ie_reg <= mdr_reg[IE_BIT];
         end
         if (wr_done && sel_q[DEV_DSR]) begin
            dsr_ie_reg <= mdr_reg[IE_BIT];
         end

         // DSR ready and disp_valid are complementary, so a DDR write and a
         // display consume can never coincide.
         if (wr_done && sel_q[DEV_DDR] && dsr_ready_reg) begin
            ddr_reg        <= mdr_reg;
            dsr_ready_reg  <= 1'b0;
            disp_valid_reg <= 1'b1;
         end else if (disp_valid_reg && disp_ready) begin
            disp_valid_reg <= 1'b0;
            dsr_ready_reg  <= 1'b1;
         end

         intr_reg <= (kbsr_ready_reg && kbsr_ie_reg) || (dsr_ready_reg && dsr_ie_reg);
      end
   end

   assign mdr_out    = mdr_reg;
   assign r          = r_reg;
   assign kbd_ready  = ~kbsr_ready_reg;
   assign disp_data  = ddr_reg[7:0];
   assign disp_valid = disp_valid_reg;
   assign intr_req   = intr_reg;

endmodule
